// File: rtl/branch_predictor_btb_pkg.sv
// Shared types for the branch predictor: mode select, BTB entry layout and counter reset value.
package bp_pkg;

  localparam int unsigned ADDR_W = 32;

  typedef enum logic {
    BP_BIMODAL = 1'b0,
    BP_GSHARE  = 1'b1
  } bp_mode_e;

  typedef enum logic {
    BTB_COND = 1'b0,
    BTB_JUMP = 1'b1
  } btb_type_e;

  // Tag is carried at full address width; only the low TAG_W bits are ever stored.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] tag;
    logic [ADDR_W-1:0] target;
    btb_type_e         kind;
  } btb_entry_t;

  // Weakly-not-taken value for a cnt_w-bit saturating counter.
  function automatic logic [3:0] cnt_reset_val(input int unsigned cnt_w);
    return 4'((1 << (cnt_w - 1)) - 1);
  endfunction

endpackage

// File: rtl/branch_predictor_btb_if.sv
// Fetch lookup, execute-stage update and statistics signals of the branch predictor.
interface branch_predictor_btb_if;

  localparam int unsigned W = bp_pkg::ADDR_W;

  logic [W-1:0] pc_f_i;
  logic         pred_taken_o;
  logic [W-1:0] pred_target_o;
  logic         pred_hit_o;

  logic         upd_valid_i;
  logic [W-1:0] upd_pc_i;
  logic         upd_is_cond_i;
  logic         upd_is_jump_i;
  logic         upd_taken_i;
  logic [W-1:0] upd_target_i;
  logic         upd_pred_taken_i;
  logic [W-1:0] upd_pred_target_i;

  logic         mispredict_o;
  logic [W-1:0] mispredict_cnt_o;
  logic [W-1:0] lookup_hit_cnt_o;

  modport master (
    output pc_f_i, upd_valid_i, upd_pc_i, upd_is_cond_i, upd_is_jump_i, upd_taken_i,
           upd_target_i, upd_pred_taken_i, upd_pred_target_i,
    input  pred_taken_o, pred_target_o, pred_hit_o, mispredict_o,
           mispredict_cnt_o, lookup_hit_cnt_o
  );

  modport slave (
    input  pc_f_i, upd_valid_i, upd_pc_i, upd_is_cond_i, upd_is_jump_i, upd_taken_i,
           upd_target_i, upd_pred_taken_i, upd_pred_target_i,
    output pred_taken_o, pred_target_o, pred_hit_o, mispredict_o,
           mispredict_cnt_o, lookup_hit_cnt_o
  );

endinterface

// File: rtl/branch_predictor_btb_sat_cnt.sv
// Next-state logic of a CNT_W-bit saturating up/down counter.
module bp_sat_cnt #(
  parameter int unsigned CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             up,
  output logic [CNT_W-1:0] nxt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  always_comb begin
    nxt = cnt;
    if (up) begin
      if (cnt != CNT_MAX) nxt = cnt + CNT_W'(1);
    end else begin
      if (cnt != '0) nxt = cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_predictor_btb.sv
// Direct-mapped BTB with bimodal or gshare direction counters; zero-latency lookup,
// update committed on the clock edge that ends the update cycle.
module branch_predictor_btb
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES = 64,
  parameter int unsigned TAG_W   = 8,
  parameter int unsigned CNT_W   = 2,
  parameter bp_mode_e    MODE    = BP_BIMODAL,
  parameter int unsigned GHR_W   = 6
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  branch_predictor_btb_if.slave  bus
);

  localparam int unsigned IDX_W  = $clog2(ENTRIES);
  localparam int unsigned TAG_LO = IDX_W + 2;
  localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(cnt_reset_val(CNT_W));

  logic                 valid_q  [ENTRIES];
  logic [TAG_W-1:0]     tag_q    [ENTRIES];
  logic [ADDR_W-1:0]    target_q [ENTRIES];
  btb_type_e            kind_q   [ENTRIES];
  logic [CNT_W-1:0]     cnt_q    [ENTRIES];
  logic [GHR_W-1:0]     ghr_q;
  logic [ADDR_W-1:0]    misp_cnt_q;
  logic [ADDR_W-1:0]    hit_cnt_q;

  logic [IDX_W-1:0]     idx_f, cidx_f, idx_u, cidx_u;
  logic [TAG_W-1:0]     tag_f, tag_u;
  btb_entry_t           rd_f;
  logic [CNT_W-1:0]     cnt_nxt;
  logic [GHR_W-1:0]     ghr_nxt;
  logic                 upd_cond, upd_jump, btb_wr;
  logic                 unused_upd_pc;

  assign idx_f  = bus.pc_f_i[TAG_LO-1:2];
  assign tag_f  = bus.pc_f_i[TAG_LO +: TAG_W];
  assign idx_u  = bus.upd_pc_i[TAG_LO-1:2];
  assign tag_u  = bus.upd_pc_i[TAG_LO +: TAG_W];
  assign cidx_f = (MODE == BP_GSHARE) ? (idx_f ^ IDX_W'(ghr_q)) : idx_f;
  assign cidx_u = (MODE == BP_GSHARE) ? (idx_u ^ IDX_W'(ghr_q)) : idx_u;
  assign unused_upd_pc = ^bus.upd_pc_i;

  // Lookup reads the arrays as they stand; a same-cycle update is not bypassed.
  always_comb begin
    rd_f = '{valid:  valid_q[idx_f],
             tag:    ADDR_W'(tag_q[idx_f]),
             target: target_q[idx_f],
             kind:   kind_q[idx_f]};
    bus.pred_hit_o    = rd_f.valid && (rd_f.tag == ADDR_W'(tag_f));
    bus.pred_taken_o  = bus.pred_hit_o &&
                        ((rd_f.kind == BTB_JUMP) || cnt_q[cidx_f][CNT_W-1]);
    bus.pred_target_o = bus.pred_taken_o ? rd_f.target : bus.pc_f_i + ADDR_W'(4);
  end

  always_comb begin
    bus.mispredict_o = bus.upd_valid_i &&
                       ((bus.upd_pred_taken_i != bus.upd_taken_i) ||
                        (bus.upd_taken_i && (bus.upd_pred_target_i != bus.upd_target_i)));
  end

  // Updates flagged as both or neither kind are ignored.
  assign upd_cond = bus.upd_valid_i && bus.upd_is_cond_i && !bus.upd_is_jump_i;
  assign upd_jump = bus.upd_valid_i && bus.upd_is_jump_i && !bus.upd_is_cond_i;
  assign btb_wr   = upd_jump || (upd_cond && bus.upd_taken_i);
  assign ghr_nxt  = GHR_W'({ghr_q, bus.upd_taken_i});

  bp_sat_cnt #(.CNT_W(CNT_W)) u_sat_cnt (
    .cnt (cnt_q[cidx_u]),
    .up  (bus.upd_taken_i),
    .nxt (cnt_nxt)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid_q[i] <= 1'b0;
        cnt_q[i]   <= CNT_RST;
      end
      ghr_q <= '0;
    end else begin
      if (btb_wr) valid_q[idx_u] <= 1'b1;
      if (upd_cond) begin
        cnt_q[cidx_u] <= cnt_nxt;
        ghr_q         <= ghr_nxt;
      end
    end
  end

  // Payload arrays need no reset: entries are qualified by valid_q.
  always_ff @(posedge clk_i) begin
    if (btb_wr) begin
      tag_q[idx_u]    <= tag_u;
      target_q[idx_u] <= bus.upd_target_i;
      kind_q[idx_u]   <= upd_jump ? BTB_JUMP : BTB_COND;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      misp_cnt_q <= '0;
      hit_cnt_q  <= '0;
    end else begin
      if (bus.mispredict_o) misp_cnt_q <= misp_cnt_q + ADDR_W'(1);
      if (bus.pred_hit_o)   hit_cnt_q  <= hit_cnt_q + ADDR_W'(1);
    end
  end

  assign bus.mispredict_cnt_o = misp_cnt_q;
  assign bus.lookup_hit_cnt_o = hit_cnt_q;

endmodule

// File: tb/tb_branch_predictor_btb.sv
// Bench for branch_predictor_btb: a bimodal and a gshare instance checked against a table-based model.
module tb_branch_predictor_btb;
  import bp_pkg::*;

  localparam int unsigned ENTRIES = 64;
  localparam int unsigned TAG_SH  = $clog2(ENTRIES) + 2;
  localparam int unsigned TAG_MOD = 256;
  localparam int          CNT_MAX = 3;
  localparam int          CNT_RST = 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [31:0] pc_f [2];
  logic [31:0] upd_pc [2];
  logic [31:0] upd_tgt [2];
  logic [31:0] upd_ptgt [2];
  logic        uv [2];
  logic        ic [2];
  logic        ij [2];
  logic        tk [2];
  logic        ptk [2];

  branch_predictor_btb_if bus0 ();
  branch_predictor_btb_if bus1 ();

  assign bus0.pc_f_i = pc_f[0];             assign bus1.pc_f_i = pc_f[1];
  assign bus0.upd_valid_i = uv[0];          assign bus1.upd_valid_i = uv[1];
  assign bus0.upd_pc_i = upd_pc[0];         assign bus1.upd_pc_i = upd_pc[1];
  assign bus0.upd_is_cond_i = ic[0];        assign bus1.upd_is_cond_i = ic[1];
  assign bus0.upd_is_jump_i = ij[0];        assign bus1.upd_is_jump_i = ij[1];
  assign bus0.upd_taken_i = tk[0];          assign bus1.upd_taken_i = tk[1];
  assign bus0.upd_target_i = upd_tgt[0];    assign bus1.upd_target_i = upd_tgt[1];
  assign bus0.upd_pred_taken_i = ptk[0];    assign bus1.upd_pred_taken_i = ptk[1];
  assign bus0.upd_pred_target_i = upd_ptgt[0]; assign bus1.upd_pred_target_i = upd_ptgt[1];

  branch_predictor_btb #(.ENTRIES(64), .TAG_W(8), .CNT_W(2), .MODE(BP_BIMODAL), .GHR_W(6)) u_bim (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus0.slave));
  branch_predictor_btb #(.ENTRIES(64), .TAG_W(8), .CNT_W(2), .MODE(BP_GSHARE), .GHR_W(2)) u_gsh (
    .clk_i(clk), .rst_ni(rst_n), .bus(bus1.slave));

  // Reference model: per-instance tables indexed by arithmetic on the PC.
  bit          m_valid [2][ENTRIES];
  int unsigned m_tag   [2][ENTRIES];
  logic [31:0] m_tgt   [2][ENTRIES];
  bit          m_jump  [2][ENTRIES];
  int          m_cnt   [2][ENTRIES];
  int unsigned m_ghr   [2];
  logic [31:0] m_misp  [2];
  logic [31:0] m_hits  [2];
  int unsigned ghr_mod [2] = '{64, 4};
  bit          gshare  [2] = '{1'b0, 1'b1};

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < ENTRIES; i++) begin
        m_valid[d][i] = 1'b0;
        m_cnt[d][i]   = CNT_RST;
      end
      m_ghr[d] = 0; m_misp[d] = '0; m_hits[d] = '0;
    end
  endfunction

  function automatic void m_pred(input int d, input logic [31:0] pc,
                                 output bit hit, output bit tkn, output logic [31:0] tgt);
    int unsigned i, ci;
    i   = (pc >> 2) % ENTRIES;
    ci  = gshare[d] ? (i ^ m_ghr[d]) : i;
    hit = m_valid[d][i] && (m_tag[d][i] == (pc >> TAG_SH) % TAG_MOD);
    tkn = hit && (m_jump[d][i] || m_cnt[d][ci] >= 2);
    tgt = tkn ? m_tgt[d][i] : pc + 32'd4;
  endfunction

  function automatic bit m_misp_of(input int d);
    return uv[d] && ((ptk[d] != tk[d]) || (tk[d] && upd_ptgt[d] != upd_tgt[d]));
  endfunction

  function automatic void obs(input int d, output logic hit, output logic tkn,
                              output logic [31:0] tgt, output logic misp,
                              output logic [31:0] mc, output logic [31:0] hc);
    if (d == 0) begin
      hit = bus0.pred_hit_o; tkn = bus0.pred_taken_o; tgt = bus0.pred_target_o;
      misp = bus0.mispredict_o; mc = bus0.mispredict_cnt_o; hc = bus0.lookup_hit_cnt_o;
    end else begin
      hit = bus1.pred_hit_o; tkn = bus1.pred_taken_o; tgt = bus1.pred_target_o;
      misp = bus1.mispredict_o; mc = bus1.mispredict_cnt_o; hc = bus1.lookup_hit_cnt_o;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, o, e);
    end
  endtask

  task automatic check_dut(input int d, output bit ehit);
    bit etk; logic [31:0] etg;
    logic h, t, m; logic [31:0] g, mc, hc;
    m_pred(d, pc_f[d], ehit, etk, etg);
    obs(d, h, t, g, m, mc, hc);
    chk($sformatf("d%0d_hit", d), 32'(h), 32'(ehit));
    chk($sformatf("d%0d_taken", d), 32'(t), 32'(etk));
    chk($sformatf("d%0d_target", d), g, etg);
    chk($sformatf("d%0d_misp", d), 32'(m), 32'(m_misp_of(d)));
    chk($sformatf("d%0d_misp_cnt", d), mc, m_misp[d]);
    chk($sformatf("d%0d_hit_cnt", d), hc, m_hits[d]);
  endtask

  task automatic model_edge(input int d, input bit ehit);
    int unsigned i, ci;
    bit cond, jmp;
    if (m_misp_of(d)) m_misp[d]++;
    if (ehit) m_hits[d]++;
    if (!uv[d]) return;
    cond = ic[d] && !ij[d];
    jmp  = ij[d] && !ic[d];
    i    = (upd_pc[d] >> 2) % ENTRIES;
    ci   = gshare[d] ? (i ^ m_ghr[d]) : i;
    if (cond) begin
      m_cnt[d][ci] = tk[d] ? ((m_cnt[d][ci] < CNT_MAX) ? m_cnt[d][ci] + 1 : CNT_MAX)
                           : ((m_cnt[d][ci] > 0) ? m_cnt[d][ci] - 1 : 0);
      m_ghr[d] = ((m_ghr[d] << 1) | 32'(tk[d])) % ghr_mod[d];
    end
    if (jmp || (cond && tk[d])) begin
      m_valid[d][i] = 1'b1;
      m_tag[d][i]   = (upd_pc[d] >> TAG_SH) % TAG_MOD;
      m_tgt[d][i]   = upd_tgt[d];
      m_jump[d][i]  = jmp;
    end
  endtask

  // One clock: check both instances before the edge, then advance the model.
  task automatic cycle();
    bit h0, h1;
    @(negedge clk);
    check_dut(0, h0);
    check_dut(1, h1);
    model_edge(0, h0);
    model_edge(1, h1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int d);
    uv[d] = 0; ic[d] = 0; ij[d] = 0; tk[d] = 0; ptk[d] = 0;
    upd_pc[d] = '0; upd_tgt[d] = '0; upd_ptgt[d] = '0;
  endtask

  task automatic set_upd(input int d, input logic [31:0] pc, input bit c, input bit j,
                         input bit t, input logic [31:0] tg, input bit pt, input logic [31:0] ptg);
    uv[d] = 1; upd_pc[d] = pc; ic[d] = c; ij[d] = j; tk[d] = t;
    upd_tgt[d] = tg; ptk[d] = pt; upd_ptgt[d] = ptg;
  endtask

  task automatic lit(input string tag, input int d, input bit eh, input bit et,
                     input logic [31:0] eg);
    logic h, t, m; logic [31:0] g, mc, hc;
    obs(d, h, t, g, m, mc, hc);
    chk({tag, "_hit"}, 32'(h), 32'(eh));
    chk({tag, "_taken"}, 32'(t), 32'(et));
    chk({tag, "_target"}, g, eg);
  endtask

  initial begin
    bit dummy, ptk_m, hm;
    logic [31:0] ptg_m;
    logic h, t, m; logic [31:0] g, mc, hc;
    logic [31:0] rpc;
    int r;

    idle(0); idle(1);
    pc_f[0] = 32'h100; pc_f[1] = 32'h300;
    model_reset();

    // Outputs held in reset.
    @(negedge clk);
    check_dut(0, dummy); check_dut(1, dummy);
    lit("rst", 0, 0, 0, 32'h104);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Two taken conditional updates at 0x100; first lookup sees pre-update state.
    set_upd(0, 32'h100, 1, 0, 1, 32'h80, 0, 32'h104);
    cycle();
    cycle();
    idle(0); #1;
    lit("two_taken", 0, 1, 1, 32'h80);
    obs(0, h, t, g, m, mc, hc);
    chk("two_taken_misp_cnt", mc, 32'd2);
    cycle();

    // Saturation at 0x140.
    pc_f[0] = 32'h140;
    for (int k = 0; k < 5; k++) begin
      set_upd(0, 32'h140, 1, 0, 1, 32'h40, 1, 32'h40);
      cycle();
    end
    set_upd(0, 32'h140, 1, 0, 0, 32'h40, 1, 32'h40);
    cycle();
    idle(0); #1;
    lit("sat_one_nt", 0, 1, 1, 32'h40);
    set_upd(0, 32'h140, 1, 0, 0, 32'h40, 1, 32'h40);
    cycle();
    cycle();
    idle(0); #1;
    lit("sat_three_nt", 0, 1, 0, 32'h144);
    cycle();

    // Jump entry and a same-index alias with a different tag.
    pc_f[0] = 32'h200;
    set_upd(0, 32'h200, 0, 1, 1, 32'h400, 0, 32'h204);
    cycle();
    idle(0); #1;
    lit("jump", 0, 1, 1, 32'h400);
    cycle();
    pc_f[0] = 32'h200 + 4 * ENTRIES; #1;
    lit("alias", 0, 0, 0, 32'h304);
    cycle();

    // Both-flag and no-flag updates change nothing but still flag mispredicts.
    pc_f[0] = 32'h140;
    set_upd(0, 32'h140, 1, 1, 1, 32'h999, 0, 32'h144);
    cycle();
    set_upd(0, 32'h140, 0, 0, 1, 32'h998, 0, 32'h144);
    cycle();
    idle(0); #1;
    lit("no_kind", 0, 1, 0, 32'h144);
    cycle();

    // Alternating branch on the gshare instance.
    pc_f[1] = 32'h300;
    for (int k = 1; k <= 8; k++) begin
      m_pred(1, 32'h300, hm, ptk_m, ptg_m);
      set_upd(1, 32'h300, 1, 0, k % 2 == 1, 32'h500, ptk_m, ptg_m);
      #1;
      if (k >= 5) begin
        obs(1, h, t, g, m, mc, hc);
        chk($sformatf("gshare_misp_k%0d", k), 32'(m), 32'd0);
        chk($sformatf("gshare_pred_k%0d", k), 32'(t), 32'(k % 2 == 1));
      end
      cycle();
    end
    idle(1);

    // Random traffic on both instances.
    for (int n = 0; n < 400; n++) begin
      for (int d = 0; d < 2; d++) begin
        pc_f[d] = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 2);
        rpc     = (32'($urandom_range(0, 7)) << 8) | (32'($urandom_range(0, 3)) << 2);
        r = $urandom_range(0, 7);
        m_pred(d, rpc, hm, ptk_m, ptg_m);
        if ($urandom_range(0, 1) == 0) begin
          ptk_m = 1'($urandom_range(0, 1));
          ptg_m = 32'($urandom_range(0, 255)) << 2;
        end
        set_upd(d, rpc, r >= 4 || r == 0, r == 2 || r == 3 || r == 0,
                1'($urandom_range(0, 1)), 32'($urandom_range(0, 255)) << 2, ptk_m, ptg_m);
        if ($urandom_range(0, 3) == 0) uv[d] = 0;
      end
      cycle();
    end

    // Reset arriving mid-update discards the update.
    idle(1);
    pc_f[0] = 32'h180;
    set_upd(0, 32'h180, 0, 1, 1, 32'h900, 0, 32'h184);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_dut(0, dummy); check_dut(1, dummy);
    lit("mid_rst", 0, 0, 0, 32'h184);
    @(posedge clk); #1;
    idle(0);
    @(negedge clk);
    check_dut(0, dummy); check_dut(1, dummy);
    rst_n = 1'b1;
    @(posedge clk); #1;
    cycle();
    lit("after_rst", 0, 0, 0, 32'h184);
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
